// File: rtl/nios_core_led_ctrl.sv
// nios_core_led_ctrl: Avalon-MM LED output controller with atomic set/clear,
// per-bit blinking driven by a prescaled tick, and an optional global PWM dimmer.
// Optional feature macro: NIOS_CORE_LED_CTRL_PWM_EN (adds DUTY register at address 6).
module nios_core_led_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned PERIOD_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [2:0] ADDR_DUTY   = 3'd6;

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_q, blink_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                phase_q, phase_d;
    logic [WIDTH-1:0]    next_out;

    logic                wr;
    logic [WIDTH-1:0]    wdata;
    logic                tick;
    logic                half_last;
    logic                toggle_pending;
    logic                pwm_gate;

    // Bits of writedata beyond WIDTH/PERIOD_W are intentionally ignored.
    logic                unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr        = chipselect && !write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign tick      = (pre_q == PRE_MAX);
    assign half_last = (half_q == (period_q - PERIOD_W'(1)));
    // Next tick will flip the phase.
    assign toggle_pending = (period_q != '0) && half_last;

`ifdef NIOS_CORE_LED_CTRL_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_cnt_q;

    // 0xFF means full on; otherwise on for duty out of every 256 clocks.
    assign pwm_gate = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_q);

    // Duty register write decode.
    always_comb begin
        duty_d = duty_q;
        if (wr && address == ADDR_DUTY) begin
            duty_d = writedata[7:0];
        end
    end

    // PWM state: duty register and free-running comparison counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= 8'hFF;
            pwm_cnt_q <= 8'd0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end
`else
    assign pwm_gate = 1'b1;
`endif

    // Register writes: DATA with atomic set/clear, BLINK mask, PERIOD.
    always_comb begin
        data_d   = data_q;
        blink_d  = blink_q;
        period_d = period_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d   = wdata;
                ADDR_BLINK:  blink_d  = wdata;
                ADDR_PERIOD: period_d = writedata[PERIOD_W-1:0];
                ADDR_OUTSET: data_d   = data_q | wdata;
                ADDR_OUTCLR: data_d   = data_q & ~wdata;
                default:     ;
            endcase
        end
    end

    // Blink engine: prescaler -> tick -> half-period counter -> phase toggle.
    // A PERIOD write restarts the engine and takes priority over a pending toggle.
    always_comb begin
        pre_d   = pre_q;
        half_d  = half_q;
        phase_d = phase_q;
        if (wr && address == ADDR_PERIOD) begin
            pre_d   = '0;
            half_d  = '0;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            pre_d   = '0;
            half_d  = '0;
            phase_d = 1'b1;
        end else if (tick) begin
            pre_d = '0;
            if (half_last) begin
                half_d  = '0;
                phase_d = ~phase_q;
            end else begin
                half_d = half_q + PERIOD_W'(1);
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Output combine: blinked bits follow phase, everything gated by PWM.
    always_comb begin
        next_out = data_q & (~blink_q | {WIDTH{phase_q}}) & {WIDTH{pwm_gate}};
    end

    // Zero-wait-state read mux, zero-extended.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_BLINK:  readdata = 32'(blink_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_STATUS: readdata = {30'd0, toggle_pending, phase_q};
`ifdef NIOS_CORE_LED_CTRL_PWM_EN
            ADDR_DUTY:   readdata = {24'd0, duty_q};
`endif
            default:     readdata = 32'd0;
        endcase
    end

    // Main state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            blink_q  <= '0;
            period_q <= '0;
            half_q   <= '0;
            pre_q    <= '0;
            phase_q  <= 1'b1;
            out_port <= '0;
        end else begin
            data_q   <= data_d;
            blink_q  <= blink_d;
            period_q <= period_d;
            half_q   <= half_d;
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            out_port <= next_out;
        end
    end

endmodule

// File: tb/tb_nios_core_led_ctrl.sv
// Directed testbench for nios_core_led_ctrl (WIDTH=8, RESET_VALUE=0xA5, PRESCALE=4).
// Define NIOS_CORE_LED_CTRL_PWM_EN to exercise the PWM build instead of the address-6 check.
module tb_nios_core_led_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks;
    int errors;

    nios_core_led_ctrl #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .PRESCALE    (4),
        .PERIOD_W    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge: the write lands on the next posedge, returns at the following negedge.
    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_low: got %h expected %h", out_port, 8'h00);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL reset_out_release: got %h expected %h", out_port, 8'hA5);
        end
        read_reg(3'd0, r);
        checks++;
        if (r !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL reset_data_read: got %h expected %h", r, 32'h0000_00A5);
        end
        read_reg(3'd2, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reset_period_read: got %h expected %h", r, 32'h0);
        end
        read_reg(3'd3, r);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL reset_status_read: got %h expected %h", r, 32'h1);
        end
    endtask

    task automatic test_set_clear;
        logic [31:0] r;
        // Three back-to-back writes on consecutive edges.
        write_reg(3'd0, 32'h0000_000F);
        write_reg(3'd4, 32'h0000_0030);
        write_reg(3'd5, 32'h0000_0003);
        // out_port lags by one edge: still shows DATA after OUTSET.
        checks++;
        if (out_port !== 8'h3F) begin
            errors++;
            $display("FAIL set_clear_lag: got %h expected %h", out_port, 8'h3F);
        end
        @(negedge clk);
        checks++;
        if (out_port !== 8'h3C) begin
            errors++;
            $display("FAIL set_clear_out: got %h expected %h", out_port, 8'h3C);
        end
        read_reg(3'd0, r);
        checks++;
        if (r !== 32'h3C) begin
            errors++;
            $display("FAIL set_clear_data: got %h expected %h", r, 32'h3C);
        end
        read_reg(3'd4, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL outset_read: got %h expected %h", r, 32'h0);
        end
        read_reg(3'd5, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL outclr_read: got %h expected %h", r, 32'h0);
        end
        read_reg(3'd7, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL addr7_read: got %h expected %h", r, 32'h0);
        end
        // Upper writedata bits are dropped on write and read back as zero.
        write_reg(3'd0, 32'hABCD_EF3C);
        read_reg(3'd0, r);
        checks++;
        if (r !== 32'h3C) begin
            errors++;
            $display("FAIL data_upper_bits: got %h expected %h", r, 32'h3C);
        end
    endtask

    task automatic test_blink;
        logic [7:0]  exp_out;
        logic [31:0] exp_st;
        write_reg(3'd0, 32'hFF);
        write_reg(3'd1, 32'h01);
        write_reg(3'd2, 32'h02);
        // Hold STATUS on the bus; reads have no side effects.
        address    = 3'd3;
        chipselect = 1'b1;
        write_n    = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            #1;
            exp_out = {7'h7F, (((k - 1) / 8) % 2) == 0};
            exp_st  = {30'd0, ((k / 4) % 2) == 1, ((k / 8) % 2) == 0};
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL blink_out k=%0d: got %h expected %h", k, out_port, exp_out);
            end
            checks++;
            if (readdata !== exp_st) begin
                errors++;
                $display("FAIL blink_status k=%0d: got %h expected %h", k, readdata, exp_st);
            end
        end
        chipselect = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_period_collision;
        logic [31:0] r;
        logic [7:0]  exp_out;
        write_reg(3'd2, 32'h02);
        repeat (7) @(negedge clk);
        // This write lands on the edge that would toggle the phase.
        write_reg(3'd2, 32'h02);
        read_reg(3'd3, r);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL collision_status: got %h expected %h", r, 32'h1);
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_out = {7'h7F, k <= 8};
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL collision_out k=%0d: got %h expected %h", k, out_port, exp_out);
            end
        end
        write_reg(3'd2, 32'h00);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            read_reg(3'd3, r);
            checks++;
            if (out_port !== 8'hFF || r !== 32'h1) begin
                errors++;
                $display("FAIL period0_steady k=%0d: got out=%h st=%h expected out=ff st=1",
                         k, out_port, r);
            end
        end
    endtask

`ifdef NIOS_CORE_LED_CTRL_PWM_EN
    task automatic test_pwm;
        logic [31:0] r;
        int          high;
        logic [7:0]  duties [3];
        int          expect_high [3];
        duties      = '{8'h40, 8'h00, 8'hFF};
        expect_high = '{64, 0, 256};
        write_reg(3'd0, 32'h01);
        write_reg(3'd1, 32'h00);
        for (int i = 0; i < 3; i++) begin
            write_reg(3'd6, {24'd0, duties[i]});
            read_reg(3'd6, r);
            checks++;
            if (r !== {24'd0, duties[i]}) begin
                errors++;
                $display("FAIL pwm_duty_read: got %h expected %h", r, duties[i]);
            end
            @(negedge clk);
            high = 0;
            for (int c = 0; c < 256; c++) begin
                @(negedge clk);
                if (out_port[0] === 1'b1) high++;
            end
            checks++;
            if (high !== expect_high[i]) begin
                errors++;
                $display("FAIL pwm_high_count duty=%h: got %0d expected %0d",
                         duties[i], high, expect_high[i]);
            end
        end
        write_reg(3'd0, 32'hFF);
        write_reg(3'd6, 32'hFF);
    endtask
`else
    task automatic test_addr6;
        logic [31:0] r;
        write_reg(3'd6, 32'h40);
        read_reg(3'd6, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL addr6_read: got %h expected %h", r, 32'h0);
        end
        @(negedge clk);
        checks++;
        if (out_port !== 8'hFF) begin
            errors++;
            $display("FAIL addr6_out: got %h expected %h", out_port, 8'hFF);
        end
    endtask
`endif

    task automatic test_reset_mid_blink;
        logic [31:0] r;
        write_reg(3'd2, 32'h02);
        repeat (10) @(negedge clk);
        checks++;
        if (out_port !== 8'hFE) begin
            errors++;
            $display("FAIL midblink_pre: got %h expected %h", out_port, 8'hFE);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL midblink_out: got %h expected %h", out_port, 8'h00);
        end
        read_reg(3'd0, r);
        checks++;
        if (r !== 32'hA5) begin
            errors++;
            $display("FAIL midblink_data: got %h expected %h", r, 32'hA5);
        end
        read_reg(3'd1, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL midblink_blink: got %h expected %h", r, 32'h0);
        end
        read_reg(3'd2, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL midblink_period: got %h expected %h", r, 32'h0);
        end
        read_reg(3'd3, r);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL midblink_status: got %h expected %h", r, 32'h1);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL midblink_release: got %h expected %h", out_port, 8'hA5);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        @(negedge clk);
        test_reset();
        test_set_clear();
        test_blink();
        test_period_collision();
`ifdef NIOS_CORE_LED_CTRL_PWM_EN
        test_pwm();
`else
        test_addr6();
`endif
        test_reset_mid_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
